load_buffer_prefetch: RTL and testbench

- Upstream companion of the memory stage: owns the two 8-entry word buffers (A, B) that the memory stage reads via buf_val_1_addr/buf_val_2_addr for buffered loads.
- On a fill request, a small FSM streams 8 consecutive words from a dedicated data-memory read port into the selected buffer.
- The buffer read ports are combinational, so buffered loads still resolve inside the memory stage's cycle.

---
 rtl/load_buffer_prefetch_pkg.sv | 19 +
 rtl/load_buffer_prefetch_bank.sv | 39 +++
 rtl/load_buffer_prefetch.sv | 166 ++++++++++++++++
 tb/tb_load_buffer_prefetch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/load_buffer_prefetch_pkg.sv
// Shared definitions for the load-buffer prefetch block: FSM encoding,
// default geometry and buffer-select constants.
package load_buffer_prefetch_pkg;

   localparam int DEPTH_DEF  = 8;
   localparam int IDX_W_DEF  = 3;
   localparam int STRIDE_DEF = 4;

   localparam logic BUF_A = 1'b0;
   localparam logic BUF_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_e;

endpackage

// File: rtl/load_buffer_prefetch_bank.sv
// DEPTH x 32 word buffer: synchronous clear, one write port, one
// combinational read port.
module load_buffer_bank
   import load_buffer_prefetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] rd_vec [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [31:0] entry_q;

         // Clear wins over a write landing on the same edge.
         always_ff @(posedge clk) begin
            if (clr_i) begin
               entry_q <= '0;
            end else if (we_i && (waddr_i == IDX_W'(gi))) begin
               entry_q <= wdata_i;
            end
         end

         assign rd_vec[gi] = entry_q;
      end
   endgenerate

   assign rdata_o = rd_vec[raddr_i];

endmodule

// File: rtl/load_buffer_prefetch.sv
// Prefetch FSM filling buffer A or B with DEPTH consecutive words.
// Optional write-through forwarding and early done: LOAD_BUF_BYPASS_EN.
module load_buffer_prefetch
   import load_buffer_prefetch_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter int STRIDE = STRIDE_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             fill_req,
   input  logic             fill_sel,
   input  logic [31:0]      fill_base_addr,
   output logic             fill_busy,
   output logic             fill_done,
   output logic             buf_a_valid,
   output logic             buf_b_valid,
   output logic             mem_rd_en,
   output logic [31:0]      mem_rd_addr,
   input  logic [31:0]      mem_rd_data,
   input  logic [IDX_W-1:0] buf_val_1_addr,
   input  logic [IDX_W-1:0] buf_val_2_addr,
   output logic [31:0]      buf_val_1_select,
   output logic [31:0]      buf_val_2_select
);

   fill_state_e      state_q, state_d;
   logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
   logic             wr_pend_q, wr_pend_d;
   logic             sel_q, sel_d;
   logic [31:0]      base_q, base_d;
   logic             valid_a_q, valid_a_d;
   logic             valid_b_q, valid_b_d;
   logic             set_valid;
   logic             accept;

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      sel_d       = sel_q;
      base_d      = base_q;
      valid_a_d   = valid_a_q;
      valid_b_d   = valid_b_q;
      set_valid   = 1'b0;
      accept      = 1'b0;
      wr_pend_d   = (state_q == ST_ISSUE);

      if (wr_pend_q) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (fill_req) begin
               accept = 1'b1;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_DRAIN;
`ifdef LOAD_BUF_BYPASS_EN
               set_valid = 1'b1;
`endif
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
`ifndef LOAD_BUF_BYPASS_EN
            set_valid = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (set_valid) begin
         if (sel_q == BUF_A) valid_a_d = 1'b1;
         else                valid_b_d = 1'b1;
      end

      // Acceptance never coincides with set_valid, so ordering is free.
      if (accept) begin
         state_d     = ST_ISSUE;
         sel_d       = fill_sel;
         base_d      = fill_base_addr & ~32'd3;
         issue_cnt_d = '0;
         wr_cnt_d    = '0;
         if (fill_sel == BUF_A) valid_a_d = 1'b0;
         else                   valid_b_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         wr_cnt_q    <= '0;
         wr_pend_q   <= 1'b0;
         sel_q       <= BUF_A;
         base_q      <= '0;
         valid_a_q   <= 1'b0;
         valid_b_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         wr_pend_q   <= wr_pend_d;
         sel_q       <= sel_d;
         base_q      <= base_d;
         valid_a_q   <= valid_a_d;
         valid_b_q   <= valid_b_d;
      end
   end

   assign fill_busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
`ifdef LOAD_BUF_BYPASS_EN
   assign fill_done   = (state_q == ST_DRAIN);
`else
   assign fill_done   = (state_q == ST_DONE);
`endif
   assign buf_a_valid = valid_a_q;
   assign buf_b_valid = valid_b_q;
   assign mem_rd_en   = (state_q == ST_ISSUE);
   assign mem_rd_addr = mem_rd_en ? (base_q + 32'(STRIDE) * 32'(issue_cnt_q)) : 32'd0;

   logic        we_a, we_b;
   logic [31:0] rdata_a, rdata_b;

   assign we_a = wr_pend_q && (sel_q == BUF_A);
   assign we_b = wr_pend_q && (sel_q == BUF_B);

   load_buffer_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank_a (
      .clk     (Clk),
      .clr_i   (~Reset),
      .we_i    (we_a),
      .waddr_i (wr_cnt_q),
      .wdata_i (mem_rd_data),
      .raddr_i (buf_val_1_addr),
      .rdata_o (rdata_a)
   );

   load_buffer_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank_b (
      .clk     (Clk),
      .clr_i   (~Reset),
      .we_i    (we_b),
      .waddr_i (wr_cnt_q),
      .wdata_i (mem_rd_data),
      .raddr_i (buf_val_2_addr),
      .rdata_o (rdata_b)
   );

`ifdef LOAD_BUF_BYPASS_EN
   // Write-through: a read of the entry being written sees the incoming word.
   assign buf_val_1_select = (we_a && (buf_val_1_addr == wr_cnt_q)) ? mem_rd_data : rdata_a;
   assign buf_val_2_select = (we_b && (buf_val_2_addr == wr_cnt_q)) ? mem_rd_data : rdata_b;
`else
   assign buf_val_1_select = rdata_a;
   assign buf_val_2_select = rdata_b;
`endif

endmodule

// File: tb/tb_load_buffer_prefetch.sv
// Randomized bench for load_buffer_prefetch against a cycle-offset
// reference model of the fill timeline (default build).
module tb_load_buffer_prefetch;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        fill_req;
   logic        fill_sel;
   logic [31:0] fill_base_addr;
   logic        fill_busy;
   logic        fill_done;
   logic        buf_a_valid;
   logic        buf_b_valid;
   logic        mem_rd_en;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic [2:0]  buf_val_1_addr;
   logic [2:0]  buf_val_2_addr;
   logic [31:0] buf_val_1_select;
   logic [31:0] buf_val_2_select;

   always #5 Clk = ~Clk;

   load_buffer_prefetch dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .fill_req         (fill_req),
      .fill_sel         (fill_sel),
      .fill_base_addr   (fill_base_addr),
      .fill_busy        (fill_busy),
      .fill_done        (fill_done),
      .buf_a_valid      (buf_a_valid),
      .buf_b_valid      (buf_b_valid),
      .mem_rd_en        (mem_rd_en),
      .mem_rd_addr      (mem_rd_addr),
      .mem_rd_data      (mem_rd_data),
      .buf_val_1_addr   (buf_val_1_addr),
      .buf_val_2_addr   (buf_val_2_addr),
      .buf_val_1_select (buf_val_1_select),
      .buf_val_2_select (buf_val_2_select)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model: a fill accepted in cycle t_acc defines everything by k = c - t_acc.
   int          t_acc;
   logic        m_sel;
   logic [31:0] m_base;
   logic [1:0]  m_valid;
   logic [31:0] ref_buf [2][8];
   bit          after_rst;

   initial begin
      int k;
      bit exp_issue;
      Reset          = 1'b0;
      fill_req       = 1'b0;
      fill_sel       = 1'b0;
      fill_base_addr = '0;
      mem_rd_data    = '0;
      buf_val_1_addr = '0;
      buf_val_2_addr = '0;
      t_acc          = -1000;
      m_sel          = 1'b0;
      m_base         = '0;
      m_valid        = '0;
      after_rst      = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 8; i++) ref_buf[b][i] = '0;

      for (int c = 0; c < 4000; c++) begin
         @(posedge Clk);
         #1;
         Reset    = (c < 3) ? 1'b0 : ($urandom_range(0, 299) != 0);
         fill_req = ($urandom_range(0, 2) == 0);
         fill_sel = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       fill_base_addr = 32'hFFFF_FFF4;
            1:       fill_base_addr = 32'h0000_0103;
            2:       fill_base_addr = 32'h0000_0100;
            default: fill_base_addr = $urandom;
         endcase
         buf_val_1_addr = 3'($urandom_range(0, 7));
         buf_val_2_addr = 3'($urandom_range(0, 7));
         mem_rd_data    = $urandom;

         @(negedge Clk);
         k = c - t_acc;
         exp_issue = (k >= 1) && (k <= 8);
         if (c >= 1) begin
            check("fill_busy", 32'(fill_busy), 32'((k >= 1) && (k <= 9)));
            check("fill_done", 32'(fill_done), 32'(k == 10));
            check("mem_rd_en", 32'(mem_rd_en), 32'(exp_issue));
            if (exp_issue)
               check("mem_rd_addr", mem_rd_addr, m_base + 32'(4 * (k - 1)));
            if (after_rst)
               check("mem_rd_addr_rst", mem_rd_addr, 32'd0);
            check("buf_a_valid", 32'(buf_a_valid), 32'(m_valid[0]));
            check("buf_b_valid", 32'(buf_b_valid), 32'(m_valid[1]));
            check("buf_val_1", buf_val_1_select, ref_buf[0][buf_val_1_addr]);
            check("buf_val_2", buf_val_2_select, ref_buf[1][buf_val_2_addr]);
            if (k == 10)
               $display("fill sel=%0d base=%h done cycle=%0d", m_sel, m_base, c);
         end

         after_rst = 1'b0;
         if (!Reset) begin
            for (int b = 0; b < 2; b++)
               for (int i = 0; i < 8; i++) ref_buf[b][i] = '0;
            m_valid   = '0;
            t_acc     = -1000;
            after_rst = 1'b1;
         end else begin
            if ((k >= 2) && (k <= 9)) ref_buf[m_sel][k - 2] = mem_rd_data;
            if (k == 9) m_valid[m_sel] = 1'b1;
            if (fill_req && !((k >= 1) && (k <= 9))) begin
               t_acc            = c;
               m_sel            = fill_sel;
               m_base           = {fill_base_addr[31:2], 2'b00};
               m_valid[fill_sel] = 1'b0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
